// File: rtl/led_scan_pkg.sv
// Shared definitions for the LED matrix scanner.
//   scan_state_t : scanner FSM states (blank gap / row drive)
//   ROWS, COLS   : matrix geometry
//   LEVEL_OFF    : all-off level before the polarity transform
//   off_level()  : physical idle level of a bus for a given polarity
package led_scan_pkg;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } scan_state_t;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    localparam logic [7:0] LEVEL_OFF = 8'h00;

    function automatic logic [7:0] off_level(input logic active_low);
        return LEVEL_OFF ^ {8{active_low}};
    endfunction

endpackage

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED matrix driver.
// Snapshots map0..map7 into a shadow buffer once per frame (at the end of
// row 0's blank gap) and scans rows with a blank gap before each row.
// Ports:
//   CLK        in   system clock
//   CLR        in   asynchronous active-high reset
//   enable     in   scan enable; low blanks the display and restarts the scan
//   map0..map7 in   playfield rows, map0 = top row
//   row        out  one-hot row select after polarity
//   col        out  column data after polarity, col[k] = bit k of the row word
//   scan_row   out  row currently scanned or about to be scanned
//   frame_done out  one-cycle pulse in the first blank cycle of the next frame
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int BLANK_CYCLES   = 1,
    parameter bit ROW_ACTIVE_LOW = 1'b0,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       enable,
    input  logic [7:0] map0,
    input  logic [7:0] map1,
    input  logic [7:0] map2,
    input  logic [7:0] map3,
    input  logic [7:0] map4,
    input  logic [7:0] map5,
    input  logic [7:0] map6,
    input  logic [7:0] map7,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic [2:0] scan_row,
    output logic       frame_done
);

    localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] DRIVE_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    localparam logic [7:0] ROW_OFF = off_level(ROW_ACTIVE_LOW);
    localparam logic [7:0] COL_OFF = off_level(COL_ACTIVE_LOW);

    scan_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]    r;
    logic [7:0]    fb    [ROWS];
    logic [7:0]    map_w [ROWS];

    assign map_w[0] = map0;
    assign map_w[1] = map1;
    assign map_w[2] = map2;
    assign map_w[3] = map3;
    assign map_w[4] = map4;
    assign map_w[5] = map5;
    assign map_w[6] = map6;
    assign map_w[7] = map7;

    assign scan_row = r;

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state      <= S_BLANK;
            cnt        <= '0;
            r          <= '0;
            row        <= ROW_OFF;
            col        <= COL_OFF;
            frame_done <= 1'b0;
            for (int i = 0; i < ROWS; i++) fb[i] <= '0;
        end else if (!enable) begin
            state      <= S_BLANK;
            cnt        <= '0;
            r          <= '0;
            row        <= ROW_OFF;
            col        <= COL_OFF;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state <= S_DRIVE;
                        cnt   <= '0;
                        row   <= (8'(1) << r) ^ ROW_OFF;
                        // Row 0 shows the words being captured this edge,
                        // so the whole frame comes from a single snapshot.
                        if (r == 3'd0) begin
                            for (int i = 0; i < ROWS; i++) fb[i] <= map_w[i];
                            col <= map_w[0] ^ COL_OFF;
                        end else begin
                            col <= fb[r] ^ COL_OFF;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (cnt == DRIVE_LAST) begin
                        state      <= S_BLANK;
                        cnt        <= '0;
                        r          <= r + 3'd1;
                        row        <= ROW_OFF;
                        col        <= COL_OFF;
                        frame_done <= (r == 3'd7);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_BLANK;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
